// File: rtl/wb_stage.sv
// Writeback stage: merges ALU results with extended load data, buffers loads that lose arbitration.
// Optional macro WB_PERF_EN adds the perf_load_stall counter port.
module wb_stage #(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        alu_valid,
  input  logic        alu_we,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_val,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_rdata,
  input  logic [2:0]  mem_funct3,
  input  logic [1:0]  mem_addr_lo,
  output logic [4:0]  rd,
  output logic        rd_write_control,
  output logic [31:0] rd_write_val
`ifdef WB_PERF_EN
  , output logic [15:0] perf_load_stall
`endif
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [4:0]  buf_rd_q  [DEPTH];
  logic [31:0] buf_val_q [DEPTH];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;

  logic [4:0]  rd_q, rd_d;
  logic        we_q, we_d;
  logic [31:0] val_q, val_d;

  logic        accept, alu_sel, pop, push, bypass, sel_valid;
  logic [4:0]  sel_rd;
  logic [31:0] sel_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign mem_ready = (count_q < FULL);
  assign accept    = mem_valid && mem_ready;
  assign alu_sel   = alu_valid && alu_we;

  // Load extension happens at accept time, so the buffer holds final write data.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (mem_addr_lo)
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      2'd3:    ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = mem_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (mem_funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Priority: ALU write, then buffer head, then the load accepted this cycle.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = alu_rd;
    sel_val   = alu_val;
    pop       = 1'b0;
    bypass    = 1'b0;
    if (alu_sel) begin
      sel_valid = 1'b1;
    end else if (count_q != 2'd0) begin
      sel_valid = 1'b1;
      pop       = 1'b1;
      sel_rd    = buf_rd_q[rd_ptr_q];
      sel_val   = buf_val_q[rd_ptr_q];
    end else if (accept) begin
      sel_valid = 1'b1;
      bypass    = 1'b1;
      sel_rd    = mem_rd;
      sel_val   = ld_ext;
    end
    push = accept && !bypass;

    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end

    // rd/val hold on idle cycles; x0 results are consumed without a write.
    rd_d  = rd_q;
    val_d = val_q;
    we_d  = 1'b0;
    if (sel_valid) begin
      rd_d  = sel_rd;
      val_d = sel_val;
      we_d  = (sel_rd != 5'd0);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      rd_q     <= 5'd0;
      we_q     <= 1'b0;
      val_q    <= 32'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      val_q    <= val_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      buf_rd_q[wr_ptr_q]  <= mem_rd;
      buf_val_q[wr_ptr_q] <= ld_ext;
    end
  end

  assign rd               = rd_q;
  assign rd_write_control = we_q;
  assign rd_write_val     = val_q;

`ifdef WB_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      perf_q <= 16'd0;
    end else if (count_q != 2'd0 && alu_sel && perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_load_stall = perf_q;
`else
  // Without the perf option there is no stall counter.
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: randomized and directed traffic against a queue-based model, with a scoreboard monitor.
`timescale 1ns/1ps
module tb_wb_stage;

  localparam int W = 69; // {expected cycle[31:0], rd[4:0], val[31:0]}

  logic        i_clk, i_rst;
  logic        alu_valid, alu_we;
  logic [4:0]  alu_rd;
  logic [31:0] alu_val;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_rdata;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic [4:0]  rd;
  logic        rd_write_control;
  logic [31:0] rd_write_val;
`ifdef WB_PERF_EN
  logic [15:0] perf_load_stall;
  logic [15:0] m_stall;
`endif

  wb_stage dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .alu_valid(alu_valid), .alu_we(alu_we), .alu_rd(alu_rd), .alu_val(alu_val),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
    .rd(rd), .rd_write_control(rd_write_control), .rd_write_val(rd_write_val)
`ifdef WB_PERF_EN
    , .perf_load_stall(perf_load_stall)
`endif
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [36:0]  mbuf[$];       // model load buffer: {rd, extended value}
  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ext_model(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] lo);
    logic [31:0] b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * (lo / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Monitor: every write must match the oldest expected entry in content and cycle.
  always @(negedge i_clk) begin
    logic [W-1:0] e;
    if (!i_rst) begin
      while (exp_q.size() > 0 && int'(exp_q[0][68:37]) < cyc) begin
        e = exp_q.pop_front();
        chk("missing_write", 1'b0, 64'(e[36:0]), 64'(e[36:0]));
      end
      if (exp_q.size() > 0 && int'(exp_q[0][68:37]) == cyc) begin
        e = exp_q.pop_front();
        chk("wb_write", rd_write_control && rd == e[36:32] && rd_write_val == e[31:0],
            {26'd0, rd_write_control, rd, rd_write_val}, {26'd0, 1'b1, e[36:0]});
      end else if (rd_write_control) begin
        chk("unexpected_write", 1'b0, {27'd0, rd, rd_write_val}, 64'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_idle();
    alu_valid = 0; alu_we = 0; alu_rd = 0; alu_val = 0;
    mem_valid = 0; mem_rd = 0; mem_rdata = 0; mem_funct3 = 0; mem_addr_lo = 0;
  endtask

  task automatic step(input bit av, input bit awe, input logic [4:0] ard, input logic [31:0] aval,
                      input bit mv, input logic [4:0] mrd, input logic [31:0] mdat,
                      input logic [2:0] f3, input logic [1:0] lo, output bit acc);
    bit sel, exp_ready;
    logic [36:0] have, ld;
    @(negedge i_clk);
    alu_valid = av; alu_we = awe; alu_rd = ard; alu_val = aval;
    mem_valid = mv; mem_rd = mrd; mem_rdata = mdat; mem_funct3 = f3; mem_addr_lo = lo;
    exp_ready = (mbuf.size() < 2);
    chk("mem_ready", mem_ready == exp_ready, 64'(mem_ready), 64'(exp_ready));
    acc = mv && exp_ready;
    ld  = {mrd, ext_model(mdat, f3, lo)};
    sel = 0;
    have = '0;
`ifdef WB_PERF_EN
    if (mbuf.size() > 0 && av && awe && m_stall != 16'hFFFF) m_stall++;
`endif
    if (av && awe) begin
      sel = 1; have = {ard, aval};
    end else if (mbuf.size() > 0) begin
      sel = 1; have = mbuf.pop_front();
    end
    if (acc) begin
      if (!sel) begin
        sel = 1; have = ld;
      end else begin
        mbuf.push_back(ld);
      end
    end
    if (sel && have[36:32] != 5'd0) exp_q.push_back({32'(cyc + 1), have});
  endtask

  task automatic idle_steps(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, a);
  endtask

  // Directly checks the write registered at the next edge against a fixed value.
  task automatic expect_wr(input string nm, input logic [4:0] erd, input logic [31:0] eval);
    @(posedge i_clk);
    #1;
    chk(nm, rd_write_control && rd == erd && rd_write_val == eval,
        {26'd0, rd_write_control, rd, rd_write_val}, {26'd0, 1'b1, erd, eval});
  endtask

  task automatic reset_mid();
    @(posedge i_clk);
    #1;
    chk("full_before_reset", mem_ready == 1'b0, 64'(mem_ready), 64'd0);
    i_rst = 1;
    #1;
    chk("rst_outputs", {rd, rd_write_control, rd_write_val} == 38'd0,
        64'({rd, rd_write_control, rd_write_val}), 64'd0);
    chk("rst_mem_ready", mem_ready == 1'b1, 64'(mem_ready), 64'd1);
`ifdef WB_PERF_EN
    chk("rst_perf", perf_load_stall == 16'd0, 64'(perf_load_stall), 64'd0);
    m_stall = 0;
`endif
    mbuf.delete();
    exp_q.delete();
    drive_idle();
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit a;
    bit p_valid;
    logic [4:0]  p_rd;
    logic [31:0] p_dat;
    logic [2:0]  p_f3;
    logic [1:0]  p_lo;
    bit av, awe;

    drive_idle();
    i_rst = 1;
`ifdef WB_PERF_EN
    m_stall = 0;
`endif
    #3;
    chk("reset_outputs", {rd, rd_write_control, rd_write_val} == 38'd0,
        64'({rd, rd_write_control, rd_write_val}), 64'd0);
    chk("reset_mem_ready", mem_ready == 1'b1, 64'(mem_ready), 64'd1);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 0;

    // ALU write and load bypass with extension
    step(1, 1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, a);
    expect_wr("alu_write", 5, 32'h1234_5678);
    step(0, 0, 0, 0, 1, 7, 32'h80FF_7F01, 3'b000, 2'd3, a);
    expect_wr("lb_bypass", 7, 32'hFFFF_FF80);
    step(0, 0, 0, 0, 1, 7, 32'h80FF_7F01, 3'b100, 2'd3, a);
    expect_wr("lbu_bypass", 7, 32'h0000_0080);
    step(0, 0, 0, 0, 1, 7, 32'h80FF_7F01, 3'b101, 2'd2, a);
    expect_wr("lhu_bypass", 7, 32'h0000_80FF);
    idle_steps(2);

    // Collision: three ALU writes, loads x8/x9 buffered, x12 refused while full then pushed on a pop
    step(1, 1, 1, 32'h11, 1, 8, 32'h0000_0088, 3'b010, 0, a);
    step(1, 1, 2, 32'h22, 1, 9, 32'h0000_0099, 3'b010, 0, a);
    step(1, 1, 3, 32'h33, 1, 12, 32'hCCCC_CCCC, 3'b010, 0, a);
    step(0, 0, 0, 0, 1, 12, 32'hCCCC_CCCC, 3'b010, 0, a);
    step(0, 0, 0, 0, 1, 12, 32'hCCCC_CCCC, 3'b010, 0, a);
    idle_steps(3);
`ifdef WB_PERF_EN
    chk("perf_collision", perf_load_stall == m_stall, 64'(perf_load_stall), 64'(m_stall));
`endif

    // x0 suppression: ALU to x0, then a buffered load to x0
    step(1, 1, 0, 32'hDEAD, 0, 0, 0, 0, 0, a);
    step(1, 1, 4, 32'h44, 1, 0, 32'h1111_2222, 3'b010, 0, a);
    idle_steps(3);

    // Simultaneous push/pop with one entry buffered
    step(1, 1, 5, 32'h55, 1, 13, 32'h0000_00F3, 3'b000, 0, a);
    step(0, 0, 0, 0, 1, 14, 32'hABCD_0000, 3'b001, 2'd2, a);
    idle_steps(3);

    // Reset with a full buffer
    step(1, 1, 6, 32'h66, 1, 10, 32'hAAAA, 3'b010, 0, a);
    step(1, 1, 7, 32'h77, 1, 11, 32'hBBBB, 3'b010, 0, a);
    reset_mid();
    idle_steps(4);

    // Random traffic; refused loads are held until accepted
    p_valid = 0;
    p_rd = 0; p_dat = 0; p_f3 = 0; p_lo = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!p_valid && $urandom_range(0, 2) != 0) begin
        p_valid = 1;
        p_rd  = 5'($urandom_range(0, 31));
        p_dat = $urandom;
        p_f3  = 3'($urandom_range(0, 7));
        p_lo  = 2'($urandom_range(0, 3));
      end
      av  = ($urandom_range(0, 9) < 6);
      awe = ($urandom_range(0, 4) != 0);
      step(av, awe, 5'($urandom_range(0, 31)), $urandom, p_valid, p_rd, p_dat, p_f3, p_lo, a);
      if (a) p_valid = 0;
    end
    idle_steps(4);
`ifdef WB_PERF_EN
    chk("perf_random", perf_load_stall == m_stall, 64'(perf_load_stall), 64'(m_stall));
`endif
    chk("drained", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
